sad_disparity_scanner: RTL and testbench

Sequential, parametrised SAD stereo-matching engine. It accepts one reference mask plus one match strip per job over a valid/ready handshake. It scans every candidate window serially, one per clock, tracking the minimum sum of absolute differences. It returns disparity, best cost, best index and a confidence flag over a second valid/ready handshake. It sits between the line-buffer/window extractor and the disparity-map writer, and it supports any window count (power of two not required) and any pixel width.

---
 rtl/sad_disparity_scanner.sv | 176 +++++++++++++++++
 tb/tb_sad_disparity_scanner.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_disparity_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// sad_disparity_scanner - serial SAD stereo matcher, one candidate window per clock. Rev 1.0
// -----------------------------------------------------------------------------
module sad_disparity_scanner #(
   parameter  int MASK_SIZE     = 3,
   parameter  int MATCH_WIDE    = 16,
   parameter  int POSITION_BITS = 11,
   parameter  int PIX_BITS      = 8,
   localparam int N             = MATCH_WIDE - (MASK_SIZE - 1),
   localparam int COST_BITS     = PIX_BITS + $clog2(MASK_SIZE * MASK_SIZE),
   localparam int IDX_BITS      = $clog2(N)
) (
   input  logic                                      aclk,
   input  logic                                      areset,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [PIX_BITS*MASK_SIZE*MASK_SIZE-1:0]   in_mask,
   input  logic [PIX_BITS*MASK_SIZE*MATCH_WIDE-1:0]  in_match,
   input  logic [POSITION_BITS-1:0]                  in_mask_pos,
   input  logic [POSITION_BITS-1:0]                  in_match_pos,
   input  logic [COST_BITS-1:0]                      in_threshold,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [7:0]                                out_disparity,
   output logic [COST_BITS-1:0]                      out_cost,
   output logic [IDX_BITS-1:0]                       out_index,
   output logic                                      out_invalid
);

   localparam logic [IDX_BITS-1:0] C_LAST = IDX_BITS'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                                   r_state;
   state_t                                   w_next_state;
   logic                                     w_accept;

   logic [PIX_BITS*MASK_SIZE*MASK_SIZE-1:0]  r_mask;
   logic [PIX_BITS*MASK_SIZE*MATCH_WIDE-1:0] r_match;
   logic [POSITION_BITS-1:0]                 r_mask_pos;
   logic [POSITION_BITS-1:0]                 r_match_pos;
   logic [COST_BITS-1:0]                     r_thr;
   logic [IDX_BITS-1:0]                      r_cnt;
   logic [COST_BITS-1:0]                     r_best_cost;
   logic [IDX_BITS-1:0]                      r_best_idx;

   logic                                     r_in_ready;
   logic                                     r_out_valid;
   logic [7:0]                               r_out_disp;
   logic [COST_BITS-1:0]                     r_out_cost;
   logic [IDX_BITS-1:0]                      r_out_idx;
   logic                                     r_out_inv;

   logic [PIX_BITS-1:0]                      w_pa;
   logic [PIX_BITS-1:0]                      w_pb;
   logic [COST_BITS-1:0]                     w_sad;
   logic                                     w_better;
   logic [COST_BITS-1:0]                     w_new_cost;
   logic [IDX_BITS-1:0]                      w_new_idx;

   logic [POSITION_BITS:0]                   w_s;
   logic [POSITION_BITS:0]                   w_mp;
   logic [POSITION_BITS:0]                   w_dd;
   logic [31:0]                              w_d32;
   logic [7:0]                               w_disp;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid && r_in_ready) begin
               w_accept     = 1'b1;
               w_next_state = S_SCAN;
            end
         end
         S_SCAN:  if (r_cnt == C_LAST) w_next_state = S_DONE;
         S_DONE:  if (out_ready)       w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Window for candidate r_cnt starts at strip column r_cnt of every row.
   always_comb begin
      w_sad = '0;
      w_pa  = '0;
      w_pb  = '0;
      for (int r = 0; r < MASK_SIZE; r++) begin
         for (int c = 0; c < MASK_SIZE; c++) begin
            w_pa  = r_mask[(r*MASK_SIZE + c)*PIX_BITS +: PIX_BITS];
            w_pb  = r_match[(r*MATCH_WIDE + c + int'(r_cnt))*PIX_BITS +: PIX_BITS];
            w_sad = w_sad + COST_BITS'((w_pa > w_pb) ? (w_pa - w_pb) : (w_pb - w_pa));
         end
      end
   end

   assign w_better   = (w_sad < r_best_cost);
   assign w_new_cost = w_better ? w_sad : r_best_cost;
   assign w_new_idx  = w_better ? r_cnt : r_best_idx;

   assign w_s    = {1'b0, r_match_pos} + (POSITION_BITS+1)'(w_new_idx);
   assign w_mp   = {1'b0, r_mask_pos};
   assign w_dd   = w_mp - w_s;
   assign w_d32  = 32'(w_dd);
   assign w_disp = (w_mp > w_s) ? ((w_d32 > 32'd255) ? 8'hFF : w_d32[7:0]) : 8'h00;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_mask      <= '0;
         r_match     <= '0;
         r_mask_pos  <= '0;
         r_match_pos <= '0;
         r_thr       <= '0;
         r_cnt       <= '0;
         r_best_cost <= '1;
         r_best_idx  <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_disp  <= '0;
         r_out_cost  <= '0;
         r_out_idx   <= '0;
         r_out_inv   <= 1'b0;
      end else begin
         r_in_ready  <= (w_next_state == S_IDLE);
         r_out_valid <= (w_next_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mask      <= in_mask;
                  r_match     <= in_match;
                  r_mask_pos  <= in_mask_pos;
                  r_match_pos <= in_match_pos;
                  r_thr       <= in_threshold;
                  r_cnt       <= '0;
                  r_best_cost <= '1;
                  r_best_idx  <= '0;
               end
            end
            S_SCAN: begin
               r_best_cost <= w_new_cost;
               r_best_idx  <= w_new_idx;
               if (r_cnt == C_LAST) begin
                  r_cnt      <= '0;
                  r_out_cost <= w_new_cost;
                  r_out_idx  <= w_new_idx;
                  r_out_disp <= w_disp;
                  r_out_inv  <= (w_new_cost > r_thr);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign out_valid     = r_out_valid;
   assign out_disparity = r_out_disp;
   assign out_cost      = r_out_cost;
   assign out_index     = r_out_idx;
   assign out_invalid   = r_out_inv;

endmodule
`default_nettype wire

// File: tb/tb_sad_disparity_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sad_disparity_scanner - randomized jobs checked against a plain SAD model. Rev 1.0
// -----------------------------------------------------------------------------
module tb_sad_disparity_scanner;

   localparam int NA = 14;
   localparam int NB = 10;

   logic aclk   = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   logic          a_iv = 1'b0, a_ir, a_ov, a_or = 1'b1, a_inv;
   logic [71:0]   a_mask = '0;
   logic [383:0]  a_match = '0;
   logic [10:0]   a_mpos = '0, a_xpos = '0;
   logic [11:0]   a_thr = '0, a_cost;
   logic [7:0]    a_disp;
   logic [3:0]    a_idx;

   logic          b_iv = 1'b0, b_ir, b_ov, b_or = 1'b1, b_inv;
   logic [71:0]   b_mask = '0;
   logic [287:0]  b_match = '0;
   logic [10:0]   b_mpos = '0, b_xpos = '0;
   logic [11:0]   b_thr = '0, b_cost;
   logic [7:0]    b_disp;
   logic [3:0]    b_idx;

   sad_disparity_scanner u_dut_a (
      .aclk(aclk), .areset(areset), .in_valid(a_iv), .in_ready(a_ir),
      .in_mask(a_mask), .in_match(a_match), .in_mask_pos(a_mpos), .in_match_pos(a_xpos),
      .in_threshold(a_thr), .out_valid(a_ov), .out_ready(a_or), .out_disparity(a_disp),
      .out_cost(a_cost), .out_index(a_idx), .out_invalid(a_inv)
   );

   sad_disparity_scanner #(.MATCH_WIDE(12)) u_dut_b (
      .aclk(aclk), .areset(areset), .in_valid(b_iv), .in_ready(b_ir),
      .in_mask(b_mask), .in_match(b_match), .in_mask_pos(b_mpos), .in_match_pos(b_xpos),
      .in_threshold(b_thr), .out_valid(b_ov), .out_ready(b_or), .out_disparity(b_disp),
      .out_cost(b_cost), .out_index(b_idx), .out_invalid(b_inv)
   );

   typedef struct {
      int cost;
      int idx;
      int disp;
      int inv;
      int acc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   mk[9];
   int   st[3][16];
   int   mpos, xpos, thr;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string nm, input int act, input int req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Exhaustive scan of all candidates with a strict-less-than minimum.
   function automatic exp_t model(input int k[9], input int s[3][16], input int n,
                                  input int mp, input int xp, input int th);
      exp_t e;
      int   sad, d, best_c, best_i, sp;
      best_c = 1 << 30;
      best_i = 0;
      for (int cand = 0; cand < n; cand++) begin
         sad = 0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
               d   = k[r*3+c] - s[r][cand+c];
               sad += (d < 0) ? -d : d;
            end
         if (sad < best_c) begin
            best_c = sad;
            best_i = cand;
         end
      end
      sp     = xp + best_i;
      e.disp = (mp > sp) ? (((mp - sp) > 255) ? 255 : (mp - sp)) : 0;
      e.cost = best_c;
      e.idx  = best_i;
      e.inv  = (best_c > th) ? 1 : 0;
      e.acc  = 0;
      return e;
   endfunction

   task automatic load_a();
      for (int i = 0; i < 9; i++) a_mask[i*8 +: 8] = 8'(mk[i]);
      for (int r = 0; r < 3; r++)
         for (int x = 0; x < 16; x++) a_match[(r*16+x)*8 +: 8] = 8'(st[r][x]);
      a_mpos = 11'(mpos);
      a_xpos = 11'(xpos);
      a_thr  = 12'(thr);
   endtask

   task automatic scramble_a();
      for (int i = 0; i < 9; i++)  a_mask[i*8 +: 8]  = 8'($urandom);
      for (int i = 0; i < 48; i++) a_match[i*8 +: 8] = 8'($urandom);
      a_mpos = 11'($urandom);
      a_xpos = 11'($urandom);
      a_thr  = 12'($urandom);
   endtask

   task automatic set_job(input int mval, input int sval, input int lo, input int hi, input int wval);
      for (int i = 0; i < 9; i++) mk[i] = mval;
      for (int r = 0; r < 3; r++)
         for (int x = 0; x < 16; x++) st[r][x] = (x >= lo && x <= hi) ? wval : sval;
   endtask

   task automatic rand_job(input int maxpix);
      for (int i = 0; i < 9; i++) mk[i] = $urandom_range(0, maxpix);
      for (int r = 0; r < 3; r++)
         for (int x = 0; x < 16; x++) st[r][x] = $urandom_range(0, maxpix);
      mpos = $urandom_range(0, 2047);
      xpos = $urandom_range(0, 2047);
      thr  = $urandom_range(0, 2400);
   endtask

   // Offer the current job; on acceptance push the model result, then optionally
   // churn the inputs for the whole scan to show the registered job is unaffected.
   task automatic run_job(input bit scramble);
      exp_t e;
      int   w;
      load_a();
      a_iv = 1'b1;
      w    = 0;
      while (!a_ir && w < 100) begin
         @(posedge aclk); #1;
         w++;
      end
      if (!a_ir) begin
         check(1'b0, "accept_timeout", 0, 1);
         a_iv = 1'b0;
         return;
      end
      e     = model(mk, st, NA, mpos, xpos, thr);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      @(posedge aclk); #1;
      a_iv = 1'b0;
      if (scramble) begin
         for (int i = 0; i < NA; i++) begin
            scramble_a();
            a_iv = (i < NA - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge aclk); #1;
         end
         a_iv = 1'b0;
      end
   endtask

   // Single checker for DUT A: every valid result, hold behaviour and reset values.
   initial begin
      int  p_valid, p_ready, p_cost, p_idx, p_disp, p_inv;
      exp_t e;
      p_valid = 0; p_ready = 0; p_cost = 0; p_idx = 0; p_disp = 0; p_inv = 0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            check(a_ir == 1'b0 && a_ov == 1'b0, "reset_hs", {30'd0, a_ir, a_ov}, 0);
            check(a_cost == 0 && a_idx == 0 && a_disp == 0 && a_inv == 1'b0, "reset_out",
                  int'(a_cost) + int'(a_idx) + int'(a_disp) + int'(a_inv), 0);
            exp_q.delete();
            p_valid = 0;
         end else if (a_ov) begin
            check(a_ir == 1'b0, "ready_while_valid", int'(a_ir), 0);
            if (!p_valid) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_valid", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check(int'(a_cost) == e.cost, "cost", int'(a_cost), e.cost);
                  check(int'(a_idx) == e.idx, "index", int'(a_idx), e.idx);
                  check(int'(a_disp) == e.disp, "disparity", int'(a_disp), e.disp);
                  check(int'(a_inv) == e.inv, "invalid", int'(a_inv), e.inv);
                  check(cyc - e.acc == NA, "latency", cyc - e.acc, NA);
               end
            end else begin
               check(p_ready == 0, "valid_after_handshake", p_ready, 0);
               check(int'(a_cost) == p_cost && int'(a_idx) == p_idx &&
                     int'(a_disp) == p_disp && int'(a_inv) == p_inv, "hold_stable",
                     int'(a_cost), p_cost);
            end
         end
         p_valid = int'(a_ov);
         p_ready = int'(a_or);
         p_cost  = int'(a_cost);
         p_idx   = int'(a_idx);
         p_disp  = int'(a_disp);
         p_inv   = int'(a_inv);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   acc, w;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      @(posedge aclk); #1;
      check(a_ir == 1'b1, "ready_after_reset", int'(a_ir), 1);

      // Best window at index 5.
      set_job(10, 200, 5, 7, 10);
      mpos = 100; xpos = 80; thr = 50;
      e = model(mk, st, NA, mpos, xpos, thr);
      check(e.idx == 5 && e.cost == 0, "model_idx5", e.idx, 5);
      check(e.disp == 15 && e.inv == 0, "model_disp15", e.disp, 15);
      run_job(1'b1);

      // All-equal pixels: earliest index wins the tie.
      set_job(7, 7, 0, -1, 7);
      mpos = 300; xpos = 200; thr = 0;
      e = model(mk, st, NA, mpos, xpos, thr);
      check(e.idx == 0 && e.cost == 0, "model_tie", e.idx, 0);
      run_job(1'b1);

      // Mask left of the strip: no positive disparity.
      rand_job(255);
      mpos = 50; xpos = 60;
      e = model(mk, st, NA, mpos, xpos, thr);
      check(e.disp == 0, "model_disp0", e.disp, 0);
      run_job(1'b0);

      // Large separation saturates.
      set_job(10, 200, 0, 2, 10);
      mpos = 1000; xpos = 0; thr = 100;
      e = model(mk, st, NA, mpos, xpos, thr);
      check(e.idx == 0 && e.disp == 255, "model_disp255", e.disp, 255);
      run_job(1'b1);

      // Threshold boundary on a uniform-cost strip.
      set_job(10, 200, 0, -1, 10);
      mpos = 500; xpos = 400; thr = 1709;
      e = model(mk, st, NA, mpos, xpos, thr);
      check(e.cost == 1710 && e.inv == 1, "model_thr1709", e.inv, 1);
      run_job(1'b0);
      thr = 1710;
      e = model(mk, st, NA, mpos, xpos, thr);
      check(e.inv == 0, "model_thr1710", e.inv, 0);
      run_job(1'b1);

      // Backpressure for 20 cycles with a competing job offered.
      rand_job(255);
      @(posedge aclk); #1;
      a_or = 1'b0;
      run_job(1'b1);
      for (int i = 0; i < 20; i++) begin
         scramble_a();
         a_iv = 1'b1;
         @(posedge aclk); #1;
      end
      a_iv = 1'b0;
      a_or = 1'b1;

      // Randomized jobs, some with narrow pixel ranges to provoke ties.
      for (int j = 0; j < 24; j++) begin
         rand_job((j % 3 == 0) ? 3 : 255);
         run_job(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) begin
            a_or = 1'b0;
            repeat ($urandom_range(1, 6)) @(posedge aclk);
            #1 a_or = 1'b1;
         end
      end

      // Reset in the middle of a scan discards the job.
      rand_job(255);
      run_job(1'b0);
      repeat (5) @(posedge aclk);
      #1 areset = 1'b1;
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      @(posedge aclk); #1;
      check(a_ir == 1'b1, "ready_after_midreset", int'(a_ir), 1);
      repeat (20) @(posedge aclk);
      #1;

      // Non-power-of-two candidate count on the second instance.
      set_job(10, 200, 9, 11, 10);
      e = model(mk, st, NB, 100, 80, 50);
      check(e.idx == 9 && e.disp == 11, "model_n10", e.idx, 9);
      for (int i = 0; i < 9; i++) b_mask[i*8 +: 8] = 8'(mk[i]);
      for (int r = 0; r < 3; r++)
         for (int x = 0; x < 12; x++) b_match[(r*12+x)*8 +: 8] = 8'(st[r][x]);
      b_mpos = 11'd100; b_xpos = 11'd80; b_thr = 12'd50;
      check(b_ir == 1'b1, "b_ready", int'(b_ir), 1);
      b_iv = 1'b1;
      @(posedge aclk); #1;
      acc  = cyc;
      b_iv = 1'b0;
      w    = 0;
      while (w < 40) begin
         @(negedge aclk);
         if (b_ov) break;
         w++;
      end
      check(b_ov == 1'b1, "b_valid_timeout", int'(b_ov), 1);
      check(cyc - acc == NB, "b_latency", cyc - acc, NB);
      check(b_idx == 4'd9, "b_index", int'(b_idx), 9);
      check(b_cost == 12'd0, "b_cost", int'(b_cost), 0);
      check(b_disp == 8'd11 && b_inv == 1'b0, "b_disparity", int'(b_disp), 11);

      repeat (40) @(posedge aclk);
      #1;
      check(exp_q.size() == 0, "results_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
